instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- Program-counter and IF/ID pipeline-register stage that sits directly upstream of the instruction memory.
- Drives the word-aligned fetch address to the memory and captures the combinational instruction it returns.
- Presents instruction, PC+4 and a valid bit to decode.
- Handles decode-stage stalls, pipeline flushes and branch/jump redirects from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- IMEM_WORDS, 1024, number of instruction words; used for the out-of-range flag.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  hazard unit requests hold of PC and IF/ID.
- Flush  input  1  squash the instruction entering IF/ID.
- Redirect  input  1  load RedirectTarget into PC (taken branch/jump).
- RedirectTarget  input  32  byte address of the redirect destination.
- Instruction  input  32  combinational instruction word from memory at PCAddress.
- PCAddress  output  32  current PC, driven to the instruction memory Address port.
- IFID_Instruction  output  32  registered instruction to decode.
- IFID_PCPlus4  output  32  registered PC+4 of that instruction.
- IFID_Valid  output  1  IF/ID holds a real instruction (0 = bubble).
- AlignFault  output  1  sticky: a misaligned RedirectTarget was received.
- OutOfRange  output  1  combinational: PCAddress[31:2] >= IMEM_WORDS.

Behaviour:
- Clock and reset: single clock Clk. Reset is synchronous and active-high. All registers update only on the rising edge of Clk.
- Reset values:
  - PC = RESET_PC.
  - IFID_Instruction = 32'h0, IFID_PCPlus4 = 32'h0, IFID_Valid = 0.
  - AlignFault = 0.
  - Reset overrides every other input.
- PC update priority per cycle (highest first):
  - Reset.
  - Redirect: PC <= {RedirectTarget[31:2], 2'b00}.
  - Stall: PC holds.
  - Otherwise: PC <= PC + 4.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 32'h0. No saturation.
- PCAddress = PC, combinational from the register. Fetch latency is zero cycles to the memory and one cycle to the IF/ID outputs.
- IF/ID update priority per cycle (highest first):
  - Reset.
  - Flush or Redirect: load bubble. IFID_Instruction <= 32'h0 (sll $0,$0,0 NOP), IFID_PCPlus4 <= 32'h0, IFID_Valid <= 0.
  - Stall: hold all three IF/ID registers.
  - Otherwise: IFID_Instruction <= Instruction, IFID_PCPlus4 <= PC + 4, IFID_Valid <= 1.
- Simultaneous inputs:
  - Redirect with Stall: redirect wins; PC loads the target and IF/ID takes a bubble.
  - Flush with Stall, no Redirect: PC holds and IF/ID takes a bubble.
  - Flush alone: PC advances normally and IF/ID takes a bubble.
- AlignFault: set on any cycle where Redirect=1 and RedirectTarget[1:0] != 0. Cleared only by Reset. The target is still loaded with the low bits forced to 0.
- Reset mid-operation (e.g. during a stall or coincident with a redirect): next-cycle state equals the reset values exactly; the pending redirect is discarded.
- OutOfRange is informational only and does not alter fetch behaviour.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, the block adds:
  - Output FetchCount (32): increments on every cycle IF/ID loads a valid instruction.
  - Output StallCount (32): increments on every cycle Stall=1 and Redirect=0 and Reset=0.
  - Both counters reset to 0, wrap modulo 2^32, and do not count during Reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then 3 free-running cycles with memory preloaded 0x20080001, 0x20090002, 0x200A0003:
  - PCAddress sequence 0x0, 0x4, 0x8, 0xC.
  - IF/ID shows 0x20080001 with PCPlus4=0x4, then 0x20090002 with PCPlus4=0x8, Valid=1.
- Stall held 2 cycles at PC=0x8:
  - PCAddress stays 0x8.
  - IF/ID holds 0x20090002 / 0x8.
  - Fetch resumes at 0xC after Stall drops.
- Redirect=1, RedirectTarget=0x40, Stall=1 at PC=0x10:
  - Next cycle PCAddress=0x40 and IFID_Valid=0.
  - The following cycle IF/ID holds mem[16] with PCPlus4=0x44.
- Redirect with RedirectTarget=0x42:
  - PCAddress=0x40 and AlignFault=1.
  - AlignFault stays 1 through 5 further cycles until Reset.
- Reset asserted coincident with Redirect to 0x80 and Flush:
  - PCAddress=RESET_PC (0x0), IFID_Valid=0, AlignFault=0.
  - With FETCH_PERF_CNT_EN defined, FetchCount=0 and StallCount=0.
- PC forced near top (RESET_PC=0xFFFFFFF8):
  - Two free-running cycles give PCAddress 0xFFFFFFFC, then 0x0.
  - OutOfRange=1 at 0xFFFFFFF8 and 0xFFFFFFFC, and 0 at 0x0.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//
// Purpose:
//   Program counter plus IF/ID pipeline register. The PC drives the
//   instruction memory address directly. The memory returns its instruction
//   combinationally in the same cycle. That word, together with PC+4, is
//   captured into IF/ID on the next rising edge.
//   The stage also handles:
//     - decode stalls,
//     - pipeline flushes,
//     - branch/jump redirects from later stages.
//
// Parameters:
//   RESET_PC    PC loaded on reset (word aligned, bits [1:0] = 0)
//   IMEM_WORDS  instruction memory depth in words; drives OutOfRange
//
// Ports:
//   Clk               in   system clock, rising edge
//   Reset             in   synchronous active-high reset, overrides everything
//   Stall             in   hold PC and IF/ID
//   Flush             in   squash the instruction entering IF/ID
//   Redirect          in   load RedirectTarget (low bits forced to 0) into PC
//   RedirectTarget    in   [31:0] redirect byte address
//   Instruction       in   [31:0] memory word at PCAddress (combinational)
//   PCAddress         out  [31:0] current PC, to memory address port
//   IFID_Instruction  out  [31:0] registered instruction for decode
//   IFID_PCPlus4      out  [31:0] registered PC+4 of that instruction
//   IFID_Valid        out  IF/ID holds a real instruction (0 = bubble)
//   AlignFault        out  sticky flag: a misaligned redirect target was seen
//   OutOfRange        out  combinational: PCAddress[31:2] >= IMEM_WORDS
//
// Optional build macro FETCH_PERF_CNT_EN adds two counters:
//   FetchCount  out  [31:0] cycles on which IF/ID loaded a valid instruction
//   StallCount  out  [31:0] cycles with Stall=1, Redirect=0, Reset=0
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic [31:0] Instruction,
  output logic [31:0] PCAddress,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        AlignFault,
  output logic        OutOfRange
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`endif
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  logic [31:0] pc_r;
  logic [31:0] pc_plus4_s;
  logic [31:0] pc_next_s;
  logic [31:0] ifid_instr_r;
  logic [31:0] ifid_pc4_r;
  logic        ifid_valid_r;
  logic        align_fault_r;
  logic        load_valid_s;

  // Wraps modulo 2^32 by construction; no saturation is wanted.
  assign pc_plus4_s = pc_r + 32'd4;

  // IF/ID takes a real instruction only when nothing squashes or holds it.
  assign load_valid_s = !Flush && !Redirect && !Stall;

  // Next PC: redirect beats stall, stall beats sequential advance.
  always_comb begin
    pc_next_s = pc_plus4_s;
    if (Redirect) begin
      pc_next_s = {RedirectTarget[31:2], 2'b00};
    end else if (Stall) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_plus4_s;
    end
  end

  // Program counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // IF/ID register: a redirect squashes the wrong-path fetch just like a flush.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ifid_instr_r <= 32'h0000_0000;
      ifid_pc4_r   <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
    end else if (Flush || Redirect) begin
      ifid_instr_r <= 32'h0000_0000;
      ifid_pc4_r   <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
    end else if (Stall) begin
      ifid_instr_r <= ifid_instr_r;
      ifid_pc4_r   <= ifid_pc4_r;
      ifid_valid_r <= ifid_valid_r;
    end else begin
      ifid_instr_r <= Instruction;
      ifid_pc4_r   <= pc_plus4_s;
      ifid_valid_r <= 1'b1;
    end
  end

  // Sticky misaligned-redirect flag; only reset clears it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      align_fault_r <= 1'b0;
    end else if (Redirect && (RedirectTarget[1:0] != 2'b00)) begin
      align_fault_r <= 1'b1;
    end else begin
      align_fault_r <= align_fault_r;
    end
  end

  assign PCAddress        = pc_r;
  assign IFID_Instruction = ifid_instr_r;
  assign IFID_PCPlus4     = ifid_pc4_r;
  assign IFID_Valid       = ifid_valid_r;
  assign AlignFault       = align_fault_r;
  // Word index is zero-extended to 32 bits so the compare is unsigned and width-matched.
  assign OutOfRange       = ({2'b00, pc_r[31:2]} >= IMEM_LIMIT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;

  // Performance counters, free-wrapping modulo 2^32.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fetch_cnt_r <= 32'h0000_0000;
      stall_cnt_r <= 32'h0000_0000;
    end else begin
      fetch_cnt_r <= load_valid_s ? (fetch_cnt_r + 32'd1) : fetch_cnt_r;
      stall_cnt_r <= (Stall && !Redirect) ? (stall_cnt_r + 32'd1) : stall_cnt_r;
    end
  end

  assign FetchCount = fetch_cnt_r;
  assign StallCount = stall_cnt_r;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_stage
//
// Purpose:
//   Directed test of instruction_fetch_stage.
//   - A behavioural model of the fetch stage is stepped once per clock and
//     compared with the DUT on every falling edge.
//   - Hand-computed literal checks pin key points of the sequence.
//   - A second instance with RESET_PC = 32'hFFFF_FFF8 exercises PC
//     wrap-around and the OutOfRange flag near the top of the address space.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, Redirect;
  logic [31:0] RedirectTarget, Instruction;
  logic [31:0] PCAddress, IFID_Instruction, IFID_PCPlus4;
  logic        IFID_Valid, AlignFault, OutOfRange;
  logic        Reset2;
  logic [31:0] Instruction2, PCAddress2, IFID_Instruction2, IFID_PCPlus42;
  logic        IFID_Valid2, AlignFault2, OutOfRange2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount, StallCount, FetchCount2, StallCount2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_align;
  logic [31:0] m_fetch, m_stalls;

  always #5 Clk = ~Clk;

  // Instruction memory content: three preloaded words, then an address tag.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr[31:2])
      30'd0:   mem_word = 32'h2008_0001;
      30'd1:   mem_word = 32'h2009_0002;
      30'd2:   mem_word = 32'h200A_0003;
      default: mem_word = 32'hC000_0000 | addr;
    endcase
  endfunction

  assign Instruction  = mem_word(PCAddress);
  assign Instruction2 = mem_word(PCAddress2);

  instruction_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(1024)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Redirect(Redirect),
    .RedirectTarget(RedirectTarget), .Instruction(Instruction),
    .PCAddress(PCAddress), .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
    .AlignFault(AlignFault), .OutOfRange(OutOfRange)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(FetchCount), .StallCount(StallCount)
`endif
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_WORDS(1024)) dut_top (
    .Clk(Clk), .Reset(Reset2), .Stall(1'b0), .Flush(1'b0), .Redirect(1'b0),
    .RedirectTarget(32'h0000_0000), .Instruction(Instruction2),
    .PCAddress(PCAddress2), .IFID_Instruction(IFID_Instruction2),
    .IFID_PCPlus4(IFID_PCPlus42), .IFID_Valid(IFID_Valid2),
    .AlignFault(AlignFault2), .OutOfRange(OutOfRange2)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(FetchCount2), .StallCount(StallCount2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model at the rising edge,
  // and return at the following falling edge.
  task automatic step(input logic rst, input logic stl, input logic fl,
                      input logic rd, input logic [31:0] tgt);
    logic [31:0] fetched;
    Reset = rst; Stall = stl; Flush = fl; Redirect = rd; RedirectTarget = tgt;
    @(posedge Clk);
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_align = 1'b0; m_fetch = 32'h0; m_stalls = 32'h0;
    end else begin
      fetched = mem_word(m_pc);
      if (rd && (tgt % 4 != 0)) m_align = 1'b1;
      if (stl && !rd) m_stalls = m_stalls + 1;
      // What decode sees next: bubble, the same thing again, or the new fetch.
      if (fl || rd) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!stl) begin
        m_instr = fetched; m_pc4 = m_pc + 4; m_valid = 1'b1;
        m_fetch = m_fetch + 1;
      end
      // Where fetch goes next.
      if (rd)        m_pc = tgt - (tgt % 4);
      else if (!stl) m_pc = m_pc + 4;
    end
    @(negedge Clk);
  endtask

  // Compare process: the DUT against the model on every falling edge.
  always @(negedge Clk) begin
    chk("pc", PCAddress, m_pc);
    chk("ifid_instr", IFID_Instruction, m_instr);
    chk("ifid_pc4", IFID_PCPlus4, m_pc4);
    chk("ifid_valid", {31'b0, IFID_Valid}, {31'b0, m_valid});
    chk("align_fault", {31'b0, AlignFault}, {31'b0, m_align});
    chk("out_of_range", {31'b0, OutOfRange}, {31'b0, (m_pc / 4) >= 1024});
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", FetchCount, m_fetch);
    chk("stall_count", StallCount, m_stalls);
`endif
  end

  initial begin
    Reset2 = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lit_reset_pc", PCAddress, 32'h0);
    chk("lit_reset_valid", {31'b0, IFID_Valid}, 32'h0);
    chk("lit_reset_instr", IFID_Instruction, 32'h0);

    // Free running from 0x0
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lit_pc_4", PCAddress, 32'h4);
    chk("lit_ifid0", IFID_Instruction, 32'h2008_0001);
    chk("lit_ifid0_pc4", IFID_PCPlus4, 32'h4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lit_pc_8", PCAddress, 32'h8);
    chk("lit_ifid1", IFID_Instruction, 32'h2009_0002);
    chk("lit_ifid1_pc4", IFID_PCPlus4, 32'h8);

    // Stall two cycles at 0x8
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("lit_stall_pc", PCAddress, 32'h8);
    chk("lit_stall_ifid", IFID_Instruction, 32'h2009_0002);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lit_resume_pc", PCAddress, 32'hC);
    chk("lit_resume_ifid", IFID_Instruction, 32'h200A_0003);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect with stall at PC=0x10
    chk("lit_pc_10", PCAddress, 32'h10);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
    chk("lit_redir_pc", PCAddress, 32'h40);
    chk("lit_redir_valid", {31'b0, IFID_Valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lit_mem16", IFID_Instruction, 32'hC000_0040);
    chk("lit_mem16_pc4", IFID_PCPlus4, 32'h44);

    // Flush alone, flush with stall, then one normal fetch
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("lit_flush_pc", PCAddress, 32'h48);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("lit_flush_stall_pc", PCAddress, 32'h48);
    chk("lit_flush_stall_valid", {31'b0, IFID_Valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Misaligned redirect; the fault must stick
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h42);
    chk("lit_misalign_pc", PCAddress, 32'h40);
    chk("lit_align_set", {31'b0, AlignFault}, 32'h1);
    for (int i = 0; i < 5; i++) step(1'b0, (i == 2), 1'b0, 1'b0, 32'h0);
    chk("lit_align_sticky", {31'b0, AlignFault}, 32'h1);

    // Reset coincident with redirect, flush and stall
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
    chk("lit_rst_pc", PCAddress, 32'h0);
    chk("lit_rst_valid", {31'b0, IFID_Valid}, 32'h0);
    chk("lit_rst_align", {31'b0, AlignFault}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("lit_rst_fetchcnt", FetchCount, 32'h0);
    chk("lit_rst_stallcnt", StallCount, 32'h0);
`endif

    // Counter activity and the IMEM_WORDS boundary
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("lit_fetchcnt", FetchCount, 32'd2);
    chk("lit_stallcnt", StallCount, 32'd3);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1000);
    chk("lit_oor_1000", {31'b0, OutOfRange}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0FFC);
    chk("lit_oor_ffc", {31'b0, OutOfRange}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lit_oor_after_ffc", {31'b0, OutOfRange}, 32'h1);

    // Wrap-around on the top-of-memory instance
    chk("lit_top_reset_pc", PCAddress2, 32'hFFFF_FFF8);
    chk("lit_top_oor0", {31'b0, OutOfRange2}, 32'h1);
    Reset2 = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lit_top_pc1", PCAddress2, 32'hFFFF_FFFC);
    chk("lit_top_oor1", {31'b0, OutOfRange2}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lit_top_pc2", PCAddress2, 32'h0);
    chk("lit_top_oor2", {31'b0, OutOfRange2}, 32'h0);
    chk("lit_top_pc4_wrap", IFID_PCPlus42, 32'h0);
    chk("lit_top_valid", {31'b0, IFID_Valid2}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
